// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and selectable FWFT read mode.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          buf_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          buf_out,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     buf_count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              rd_acc;
    logic              wr_acc;

    // Every status flag comes from the registered count, so none can glitch on inputs.
    assign buf_count    = count_reg;
    assign buf_empty    = (count_reg == '0);
    assign buf_full     = (count_reg == CNT_W'(DEPTH));
    assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A write at full is still legal when a read frees the slot in the same cycle.
    assign rd_acc = rd_en & ~buf_empty & ~clr;
    assign wr_acc = wr_en & (~buf_full | rd_en) & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (wr_en & ~wr_acc)    overflow_reg  <= 1'b1;
            if (rd_en & buf_empty)  underflow_reg <= 1'b1;
        end
    end

    // Storage has no reset so it can map onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) mem[wr_ptr_reg] <= buf_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; rd_en only acknowledges it.
            assign buf_out = buf_empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_std
            logic [DATA_W-1:0] buf_out_reg;
            // At full with a simultaneous write, wr_ptr == rd_ptr; the read sees the old word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      buf_out_reg <= '0;
                else if (rd_acc) buf_out_reg <= mem[rd_ptr_reg];
            end
            assign buf_out = buf_out_reg;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param; a registered-read and an FWFT
// instance share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] buf_in = '0;

    logic [DW-1:0] out0, out1;
    logic          empty0, full0, af0, ae0, ovf0, unf0;
    logic          empty1, full1, af1, ae1, ovf1, unf1;
    logic [4:0]    cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_out0 = '0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
        .buf_out(out0), .buf_empty(empty0), .buf_full(full0), .almost_full(af0),
        .almost_empty(ae0), .buf_count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
        .buf_out(out1), .buf_empty(empty1), .buf_full(full1), .almost_full(af1),
        .almost_empty(ae1), .buf_count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0h expected=%0h", tag, txn, got, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        check_val("count0", 32'(cnt0), 32'(n));
        check_val("count1", 32'(cnt1), 32'(n));
        check_val("empty0", 32'(empty0), 32'(n == 0));
        check_val("empty1", 32'(empty1), 32'(n == 0));
        check_val("full0", 32'(full0), 32'(n == DP));
        check_val("full1", 32'(full1), 32'(n == DP));
        check_val("afull0", 32'(af0), 32'(n >= AF));
        check_val("afull1", 32'(af1), 32'(n >= AF));
        check_val("aempty0", 32'(ae0), 32'(n <= AE));
        check_val("aempty1", 32'(ae1), 32'(n <= AE));
        check_val("ovf0", 32'(ovf0), 32'(m_ovf));
        check_val("ovf1", 32'(ovf1), 32'(m_ovf));
        check_val("unf0", 32'(unf0), 32'(m_unf));
        check_val("unf1", 32'(unf1), 32'(m_unf));
        check_val("out_reg", 32'(out0), 32'(m_out0));
        if (n != 0) check_val("out_fwft", 32'(out1), 32'(model_q[0]));
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_out0 = '0;
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit was_full, was_empty, racc, wacc;
        wr_en = w; rd_en = r; clr = c; buf_in = d;
        @(posedge clk);
        was_full  = (model_q.size() == DP);
        was_empty = (model_q.size() == 0);
        if (c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            racc = r && !was_empty;
            wacc = w && (!was_full || r);
            if (w && !wacc) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (racc) m_out0 = model_q.pop_front();
            if (wacc) model_q.push_back(d);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        txn++;
        $display("txn %0d wr=%0b rd=%0b clr=%0b din=%02h count=%0d out=%02h fwft_out=%02h",
                 txn, w, r, c, d, cnt0, out0, out1);
        check_all();
    endtask

    initial begin
        int bias;
        // Reset held for two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Short write/read burst, almost_empty edges at 3 and 2
        step(1, 0, 0, 8'hA1); step(1, 0, 0, 8'hB2);
        step(1, 0, 0, 8'hC3); step(1, 0, 0, 8'hD4);
        repeat (4) step(0, 1, 0, 8'h00);

        // Fill, overflow, drain across the pointer wrap
        for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
        step(1, 0, 0, 8'hEE);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);

        // Simultaneous read/write at full
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h20 + i));
        step(1, 1, 0, 8'h55);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);

        // Underflow at empty, simultaneous read/write at empty, then flush
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h77);
        step(0, 0, 1, 8'h00);

        // FWFT head visible without a read
        step(1, 0, 0, 8'hE5);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);

        // Randomised traffic with slowly changing fill/drain bias
        bias = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) bias = $urandom_range(20, 80);
            step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 100 - bias),
                 ($urandom_range(0, 63) == 0), 8'($urandom));
        end

        // Asynchronous reset in the middle of a write burst
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h90 + i));
        wr_en = 1'b1; buf_in = 8'h94;
        #2;
        rst_n = 1'b0;
        #1;
        wr_en = 1'b0;
        model_reset();
        txn++;
        $display("txn %0d async reset mid-burst count=%0d empty=%0b", txn, cnt0, empty0);
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'hC0 + i));
        repeat (3) step(0, 1, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
